// File: rtl/multicycle_control_unit.sv
// Multi-cycle main control unit: accepts one instruction over a valid/ready
// handshake, then walks it through DECODE, EXEC (EXEC_CYCLES long, stallable)
// and WB. It drives registered control signals to the multi-cycle datapath.
module multicycle_control_unit #(
  parameter int INSTR_W     = 32,
  parameter int ALUOP_W     = 4,
  parameter int EXEC_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] Instruction_Code,
  input  logic               stall,
  output logic               RegWrite,
  output logic               Imm_Sel,
  output logic               ALU_Src,
  output logic [ALUOP_W-1:0] ALU_op,
  output logic               done,
  output logic               illegal
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(EXEC_CYCLES - 1);

  state_t             state;
  state_t             state_next;
  logic [INSTR_W-1:0] instr_q;
  logic [3:0]         exec_cnt;
  logic               exec_last;
  logic [3:0]         dec_op;
  logic               dec_ill;
  logic               unused_instr;

  // Only bit 26 and the funct field are decoded; fold the rest into a sink.
  assign unused_instr = ^instr_q;

  assign instr_ready = (state == IDLE);
  assign exec_last   = (exec_cnt == LAST_CNT);

  // Next-state selection for the IDLE/DECODE/EXEC/WB sequence.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (instr_valid) state_next = DECODE;
      DECODE:  state_next = EXEC;
      EXEC:    if (!stall && exec_last) state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ALU operation decode of the captured instruction.
  always_comb begin
    dec_op  = 4'b1111;
    dec_ill = 1'b1;
    if (instr_q[26]) begin
      dec_op  = 4'b0010;
      dec_ill = 1'b0;
    end else begin
      case (instr_q[5:0])
        6'h20:   begin dec_op = 4'b0010; dec_ill = 1'b0; end
        6'h22:   begin dec_op = 4'b0110; dec_ill = 1'b0; end
        6'h24:   begin dec_op = 4'b0000; dec_ill = 1'b0; end
        6'h25:   begin dec_op = 4'b0001; dec_ill = 1'b0; end
        6'h2A:   begin dec_op = 4'b0111; dec_ill = 1'b0; end
        default: begin dec_op = 4'b1111; dec_ill = 1'b1; end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Capture the instruction on the accepting handshake edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                           instr_q <= '0;
    else if (state == IDLE && instr_valid) instr_q <= Instruction_Code;
  end

  // EXEC cycle counter: zero outside EXEC, advances on unstalled EXEC cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              exec_cnt <= '0;
    else if (state != EXEC)  exec_cnt <= '0;
    else if (!stall)         exec_cnt <= exec_cnt + 4'd1;
  end

  // Control registers load on the DECODE -> EXEC edge and hold until the next one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Imm_Sel <= 1'b0;
      ALU_Src <= 1'b0;
      ALU_op  <= '0;
      illegal <= 1'b0;
    end else if (state == DECODE) begin
      Imm_Sel <= ~instr_q[26];
      ALU_Src <= (instr_q[5] ~^ instr_q[4]) | instr_q[26];
      ALU_op  <= ALUOP_W'(dec_op);
      illegal <= dec_ill;
    end
  end

  // Write-back pulses, registered so they are high exactly during WB.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done     <= 1'b0;
      RegWrite <= 1'b0;
    end else begin
      done     <= (state_next == WB);
      RegWrite <= (state_next == WB) & ~illegal;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit. A behavioural model tracks
// each accepted instruction by its "age" in cycles and derives every output
// from that age and the decode table; literal expectations pin the model.
module tb_multicycle_control_unit;

  localparam int IW = 32;
  localparam int AW = 5;
  localparam int EC = 3;

  logic          clk;
  logic          reset;
  logic          instr_valid;
  logic          instr_ready;
  logic [IW-1:0] Instruction_Code;
  logic          stall;
  logic          RegWrite;
  logic          Imm_Sel;
  logic          ALU_Src;
  logic [AW-1:0] ALU_op;
  logic          done;
  logic          illegal;

  int nVec  = 0;
  int nFail = 0;

  // Model state: busy flag, age of the in-flight instruction, and held controls.
  bit          mBusy;
  int          mAge;
  logic [31:0] mInstr;
  logic        mImm;
  logic        mSrc;
  logic [4:0]  mOp;
  logic        mIll;

  logic [5:0] legalFunct [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

  multicycle_control_unit #(
    .INSTR_W    (IW),
    .ALUOP_W    (AW),
    .EXEC_CYCLES(EC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .Instruction_Code(Instruction_Code),
    .stall           (stall),
    .RegWrite        (RegWrite),
    .Imm_Sel         (Imm_Sel),
    .ALU_Src         (ALU_Src),
    .ALU_op          (ALU_op),
    .done            (done),
    .illegal         (illegal)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Decode table: I-type is always add; R-type uses the funct lookup.
  function automatic void modelDecode(input logic [31:0] ins, output logic [4:0] op,
                                      output logic ill);
    op  = 5'h0F;
    ill = 1'b1;
    if (ins[26]) begin
      op = 5'h02; ill = 1'b0;
    end else if (ins[5:0] == 6'h20) begin op = 5'h02; ill = 1'b0; end
    else if (ins[5:0] == 6'h22) begin op = 5'h06; ill = 1'b0; end
    else if (ins[5:0] == 6'h24) begin op = 5'h00; ill = 1'b0; end
    else if (ins[5:0] == 6'h25) begin op = 5'h01; ill = 1'b0; end
    else if (ins[5:0] == 6'h2A) begin op = 5'h07; ill = 1'b0; end
  endfunction

  task automatic modelReset();
    mBusy  = 1'b0;
    mAge   = 0;
    mInstr = '0;
    mImm   = 1'b0;
    mSrc   = 1'b0;
    mOp    = '0;
    mIll   = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  // Age 1 is decode, ages 2..EC+1 are execute (frozen by stall), age EC+2 is write-back.
  task automatic modelStep();
    if (!reset) begin
      modelReset();
    end else if (!mBusy) begin
      if (instr_valid) begin
        mBusy  = 1'b1;
        mAge   = 1;
        mInstr = Instruction_Code;
      end
    end else if (mAge == EC + 2) begin
      mBusy = 1'b0;
    end else begin
      if (mAge == 1) begin
        mImm = ~mInstr[26];
        mSrc = (mInstr[5] == mInstr[4]) || mInstr[26];
        modelDecode(mInstr, mOp, mIll);
      end
      if (!(mAge >= 2 && stall)) mAge = mAge + 1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model for the current cycle.
  task automatic compareModel();
    logic expDone;
    expDone = mBusy && (mAge == EC + 2);
    checkOutput("instr_ready", 32'(instr_ready), 32'(!mBusy));
    checkOutput("done",        32'(done),        32'(expDone));
    checkOutput("RegWrite",    32'(RegWrite),    32'(expDone && !mIll));
    checkOutput("Imm_Sel",     32'(Imm_Sel),     32'(mImm));
    checkOutput("ALU_Src",     32'(ALU_Src),     32'(mSrc));
    checkOutput("ALU_op",      32'(ALU_op),      32'(mOp));
    checkOutput("illegal",     32'(illegal),     32'(mIll));
  endtask

  // Drive inputs (a low rst asserts reset asynchronously right now), then
  // compare outputs on the following falling edge.
  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic st,
                               input logic rst);
    instr_valid      = v;
    Instruction_Code = ins;
    stall            = st;
    reset            = rst;
    if (!rst) modelReset();
    @(negedge clk);
    compareModel();
  endtask

  task automatic finishClock();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  function automatic logic [31:0] mkInstr(input logic typ, input logic [5:0] funct);
    logic [31:0] r;
    r       = $urandom;
    r[26]   = typ;
    r[5:0]  = funct;
    return r;
  endfunction

  // Directed scenarios with pinned literal expectations, then randomized traffic.
  initial begin
    logic [31:0] insA;
    logic [31:0] insB;
    logic        v;
    logic        st;
    logic        rst;
    int          rstHold;

    reset = 1'b0; instr_valid = 1'b0; stall = 1'b0; Instruction_Code = '0;
    modelReset();

    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("lit_reset_ready", 32'(instr_ready), 32'd1);
      checkOutput("lit_reset_op", 32'(ALU_op), 32'd0);
      finishClock();
    end

    // R-type add.
    insA = mkInstr(1'b0, 6'h20);
    for (int c = 0; c < 7; c++) begin
      applyStimulus(c == 0, insA, 1'b0, 1'b1);
      if (c == 0) checkOutput("lit_add_ready_c0", 32'(instr_ready), 32'd1);
      if (c == 1) checkOutput("lit_add_ready_c1", 32'(instr_ready), 32'd0);
      if (c == 2) begin
        checkOutput("lit_add_op", 32'(ALU_op), 32'h2);
        checkOutput("lit_add_imm", 32'(Imm_Sel), 32'd1);
        checkOutput("lit_add_src", 32'(ALU_Src), 32'd0);
        checkOutput("lit_add_done_c2", 32'(done), 32'd0);
      end
      if (c == 5) begin
        checkOutput("lit_add_done_wb", 32'(done), 32'd1);
        checkOutput("lit_add_rw_wb", 32'(RegWrite), 32'd1);
      end
      if (c == 6) begin
        checkOutput("lit_add_ready_c6", 32'(instr_ready), 32'd1);
        checkOutput("lit_add_rw_c6", 32'(RegWrite), 32'd0);
        checkOutput("lit_add_op_hold", 32'(ALU_op), 32'h2);
      end
      finishClock();
    end

    // I-type.
    insA = mkInstr(1'b1, 6'h00);
    for (int c = 0; c < 6; c++) begin
      applyStimulus(c == 0, insA, 1'b0, 1'b1);
      if (c == 2) begin
        checkOutput("lit_itype_imm", 32'(Imm_Sel), 32'd0);
        checkOutput("lit_itype_src", 32'(ALU_Src), 32'd1);
        checkOutput("lit_itype_op", 32'(ALU_op), 32'h2);
        checkOutput("lit_itype_ill", 32'(illegal), 32'd0);
      end
      if (c == 5) checkOutput("lit_itype_rw", 32'(RegWrite), 32'd1);
      finishClock();
    end

    // Illegal R-type funct 0x3F.
    insA = mkInstr(1'b0, 6'h3F);
    for (int c = 0; c < 7; c++) begin
      applyStimulus(c == 0, insA, 1'b0, 1'b1);
      if (c == 2) begin
        checkOutput("lit_ill_op", 32'(ALU_op), 32'h0F);
        checkOutput("lit_ill_flag", 32'(illegal), 32'd1);
        checkOutput("lit_ill_src", 32'(ALU_Src), 32'd1);
      end
      if (c == 5) begin
        checkOutput("lit_ill_done", 32'(done), 32'd1);
        checkOutput("lit_ill_rw", 32'(RegWrite), 32'd0);
      end
      finishClock();
    end

    // Sub with two stall cycles in the middle of EXEC: WB moves from cycle 5 to 7.
    insA = mkInstr(1'b0, 6'h22);
    for (int c = 0; c < 9; c++) begin
      applyStimulus(c == 0, insA, (c == 3 || c == 4), 1'b1);
      if (c == 4) checkOutput("lit_stall_op", 32'(ALU_op), 32'h6);
      if (c == 5) checkOutput("lit_stall_done_c5", 32'(done), 32'd0);
      if (c == 6) checkOutput("lit_stall_done_c6", 32'(done), 32'd0);
      if (c == 7) begin
        checkOutput("lit_stall_done_c7", 32'(done), 32'd1);
        checkOutput("lit_stall_rw_c7", 32'(RegWrite), 32'd1);
      end
      if (c == 8) checkOutput("lit_stall_ready_c8", 32'(instr_ready), 32'd1);
      finishClock();
    end

    // Reset in the middle of EXEC aborts the instruction.
    insA = mkInstr(1'b0, 6'h24);
    for (int c = 0; c < 9; c++) begin
      applyStimulus(c == 0, insA, 1'b0, !(c == 3 || c == 4));
      if (c == 2) checkOutput("lit_abort_imm_before", 32'(Imm_Sel), 32'd1);
      if (c == 3) begin
        checkOutput("lit_abort_ready", 32'(instr_ready), 32'd1);
        checkOutput("lit_abort_imm", 32'(Imm_Sel), 32'd0);
        checkOutput("lit_abort_op", 32'(ALU_op), 32'd0);
      end
      if (c >= 5) begin
        checkOutput("lit_abort_rw", 32'(RegWrite), 32'd0);
        checkOutput("lit_abort_ready_after", 32'(instr_ready), 32'd1);
      end
      finishClock();
    end

    // Back-to-back: valid held high; B offered during A's WB waits for IDLE.
    insA = mkInstr(1'b0, 6'h25);
    insB = mkInstr(1'b0, 6'h2A);
    for (int c = 0; c < 13; c++) begin
      applyStimulus(c < 12, (c == 0) ? insA : insB, 1'b0, 1'b1);
      if (c == 5) begin
        checkOutput("lit_b2b_ready_wb", 32'(instr_ready), 32'd0);
        checkOutput("lit_b2b_done_wb", 32'(done), 32'd1);
      end
      if (c == 6) begin
        checkOutput("lit_b2b_ready_idle", 32'(instr_ready), 32'd1);
        checkOutput("lit_b2b_op_a", 32'(ALU_op), 32'h1);
      end
      if (c == 7) checkOutput("lit_b2b_op_a_dec", 32'(ALU_op), 32'h1);
      if (c == 8) checkOutput("lit_b2b_op_b", 32'(ALU_op), 32'h7);
      if (c == 11) checkOutput("lit_b2b_done_b", 32'(done), 32'd1);
      finishClock();
    end

    // Randomized traffic with stalls and occasional asynchronous resets.
    rstHold = 0;
    for (int c = 0; c < 800; c++) begin
      v = ($urandom_range(0, 1) == 1);
      st = ($urandom_range(0, 3) == 0);
      if (rstHold > 0) rstHold--;
      else if ($urandom_range(0, 79) == 0) rstHold = $urandom_range(1, 2);
      rst = (rstHold == 0);
      if ($urandom_range(0, 9) < 7)
        insA = mkInstr(1'($urandom_range(0, 1)), legalFunct[$urandom_range(0, 4)]);
      else
        insA = mkInstr(1'($urandom_range(0, 1)), 6'($urandom));
      applyStimulus(v, insA, st, rst);
      finishClock();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Parametrised successor to the single-cycle main control decoder. It accepts one instruction at a time over a valid/ready handshake, registers it, and sequences it through DECODE, EXEC and WB states. It drives registered control signals (RegWrite, Imm_Sel, ALU_Src, ALU_op) plus done and illegal flags to the multi-cycle datapath. It sits between the instruction fetch stage and the register file / ALU.

Parameters:
INSTR_W, 32, instruction width; must be >= 27 (bit 26 is the type bit).
ALUOP_W, 4, ALU_op width; must be >= 4.
EXEC_CYCLES, 1, number of EXEC-state cycles per instruction; legal range 1..15.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
instr_valid  input  1  Instruction_Code is valid this cycle.
instr_ready  output  1  unit can accept an instruction (high only in IDLE).
Instruction_Code  input  INSTR_W  instruction; bit 26 is the type bit (0 = R-type, 1 = I-type); bits [5:0] are funct.
stall  input  1  freezes the EXEC cycle counter.
RegWrite  output  1  register-file write enable; high only in WB for legal instructions.
Imm_Sel  output  1  immediate select = ~instr[26].
ALU_Src  output  1  = (funct[5] XNOR funct[4]) OR instr[26].
ALU_op  output  ALUOP_W  ALU operation code.
done  output  1  one-cycle pulse in WB.
illegal  output  1  current instruction is an undecodable R-type.

Behaviour:
- States: IDLE, DECODE, EXEC, WB, held in a registered state variable.
- instr_ready = (state == IDLE); decoded from the registered state.
- IDLE -> DECODE on instr_valid & instr_ready. Instruction_Code is captured into an internal register on that edge. instr_valid without ready is ignored; no buffering.
- DECODE (exactly 1 cycle): control registers load from the captured instruction on the DECODE -> EXEC edge.
- Decode rules:
  - Imm_Sel = ~i[26].
  - ALU_Src = (i[5] ~^ i[4]) | i[26].
  - I-type: ALU_op = 4'b0010 (add); illegal = 0.
  - R-type, funct mapping: 0x20 -> 0010, 0x22 -> 0110, 0x24 -> 0000, 0x25 -> 0001, 0x2A -> 0111.
  - R-type, any other funct: ALU_op = 4'b1111 and illegal = 1.
  - ALU_op is zero-extended when ALUOP_W > 4.
- EXEC:
  - Cycle counter loads 0 on entry and increments each cycle stall = 0.
  - While stall = 1, the counter, state and all outputs hold.
  - EXEC -> WB when the counter reaches EXEC_CYCLES-1 with stall = 0.
- WB (exactly 1 cycle; stall has no effect):
  - done = 1.
  - RegWrite = ~illegal.
  - Next state is IDLE.
- Control hold: Imm_Sel, ALU_Src, ALU_op and illegal stay constant from EXEC entry until the next DECODE -> EXEC edge. They remain visible in IDLE.
- Output timing: RegWrite and done are registered, asserted only in WB, and zero elsewhere.
- Latency: handshake edge at cycle 0; DECODE at cycle 1; EXEC at cycles 2..EXEC_CYCLES+1; WB at cycle EXEC_CYCLES+2; instr_ready high again at cycle EXEC_CYCLES+3. Throughput is one instruction per EXEC_CYCLES+3 cycles.
- Reset (reset = 0, asynchronous, any state including mid-EXEC or WB):
  - state goes to IDLE; captured instruction and counter are cleared.
  - RegWrite, Imm_Sel, ALU_Src, done and illegal go to 0; ALU_op goes to 0.
  - instr_ready = 1 while in IDLE after reset.
  - No write completes for an aborted instruction.
- instr_valid is a don't-care outside IDLE. An instruction presented in the WB cycle is not accepted until the following IDLE cycle.

Test Plan:
1. EXEC_CYCLES=1; reset, then R-type add (i[26]=0, funct 0x20) with valid=1 for one cycle -> Imm_Sel=1, ALU_Src=0, ALU_op=0010 from cycle 2; RegWrite=1 and done=1 in cycle 3 only; instr_ready back high in cycle 4.
2. I-type (i[26]=1, funct 0x00) -> Imm_Sel=0, ALU_Src=1, ALU_op=0010, illegal=0; RegWrite pulses in WB.
3. R-type funct 0x3F -> ALU_op=1111 and illegal=1 from EXEC entry; WB has done=1 and RegWrite=0.
4. EXEC_CYCLES=3 with stall high for 2 cycles mid-EXEC -> WB at cycle 7 instead of 5; outputs stable throughout the stall.
5. reset asserted during EXEC -> immediate IDLE with all outputs 0 and instr_ready=1 after deassertion; no RegWrite pulse.
6. Back-to-back valid held high -> second instruction accepted only in the IDLE cycle after WB; its decode replaces the controls at its own EXEC entry.
